// File: rtl/dma_req_splitter.sv
// dma_req_splitter
//   Accepts byte-range DMA requests and splits each into chunk commands that
//   never cross an XFER_SIZE-aligned boundary. Issue is throttled by a count
//   of chunks that are still waiting for a completion.
//
// Ports
//   aclk, aresetn          clock, async active-low reset
//   s_req_*                request in (valid/ready, addr, len, ctl, vfid)
//   m_cmd_*                chunk command out (valid/ready, addr, len, ctl)
//   cpl_valid              one pulse per completed chunk
//   outstanding            chunks issued and not yet completed
//   busy                   request in progress or completions pending
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request; s_req_ready high once out of reset
// ISSUE | emitting chunks of the latched request
//
// XFER_SIZE must be a power of two in the range 64 .. 2^27 so that a full
// chunk still fits the 28-bit length field.
module dma_req_splitter #(
  parameter int unsigned XFER_SIZE       = 4096,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned OUTW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            s_req_valid,
  output logic            s_req_ready,
  input  logic [63:0]     s_req_addr,
  input  logic [27:0]     s_req_len,
  input  logic            s_req_ctl,
  input  logic [3:0]      s_req_vfid,
  output logic            m_cmd_valid,
  input  logic            m_cmd_ready,
  output logic [63:0]     m_cmd_addr,
  output logic [27:0]     m_cmd_len,
  output logic [15:0]     m_cmd_ctl,
  input  logic            cpl_valid,
  output logic [OUTW-1:0] outstanding,
  output logic            busy
);

  localparam int unsigned OFFW = $clog2(XFER_SIZE);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              ready_en_q, ready_en_d;
  logic [63:0]       cur_addr_q, cur_addr_d;
  logic [27:0]       rem_len_q, rem_len_d;
  logic              ctl_q, ctl_d;
  logic [3:0]        vfid_q, vfid_d;
  logic [OUTW-1:0]   outstanding_q, outstanding_d;

  logic [OFFW-1:0]   addr_off;
  logic [OFFW:0]     room;
  logic [27:0]       room_len;
  logic [27:0]       chunk_len;
  logic              last_chunk;
  logic              out_full;
  logic              req_hs;
  logic              cmd_hs;
  logic              cpl_eff;

  // Chunk geometry comes only from registered state, so m_cmd_* holds
  // steady under backpressure without extra capture registers.
  assign addr_off   = cur_addr_q[OFFW-1:0];
  assign room       = (OFFW + 1)'(XFER_SIZE) - {1'b0, addr_off};
  assign room_len   = 28'(room);
  assign chunk_len  = (rem_len_q < room_len) ? rem_len_q : room_len;
  assign last_chunk = (chunk_len == rem_len_q);
  assign out_full   = (outstanding_q == OUTW'(MAX_OUTSTANDING));
  assign req_hs     = s_req_valid & s_req_ready;
  assign cmd_hs     = m_cmd_valid & m_cmd_ready;
  // A completion with nothing in flight is stale and ignored.
  assign cpl_eff    = cpl_valid & (outstanding_q != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      ready_en_q    <= 1'b0;
      cur_addr_q    <= '0;
      rem_len_q     <= '0;
      ctl_q         <= 1'b0;
      vfid_q        <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      ready_en_q    <= ready_en_d;
      cur_addr_q    <= cur_addr_d;
      rem_len_q     <= rem_len_d;
      ctl_q         <= ctl_d;
      vfid_q        <= vfid_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    ctl_d      = ctl_q;
    vfid_d     = vfid_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          cur_addr_d = s_req_addr;
          rem_len_d  = s_req_len;
          ctl_d      = s_req_ctl;
          vfid_d     = s_req_vfid;
          // Zero-length requests are consumed and dropped.
          if (s_req_len != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_hs) begin
          cur_addr_d = cur_addr_q + 64'(chunk_len);
          rem_len_d  = rem_len_q - chunk_len;
          if (last_chunk) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    outstanding_d = outstanding_q;
    if (cmd_hs && !cpl_eff) begin
      outstanding_d = outstanding_q + OUTW'(1);
    end else if (!cmd_hs && cpl_eff) begin
      outstanding_d = outstanding_q - OUTW'(1);
    end
  end

  always_comb begin
    s_req_ready = ready_en_q && (state_q == IDLE);
    m_cmd_valid = (state_q == ISSUE) && !out_full;
    m_cmd_addr  = cur_addr_q;
    m_cmd_len   = chunk_len;
    m_cmd_ctl   = {8'h00, vfid_q, 3'b000, last_chunk & ctl_q};
    outstanding = outstanding_q;
    busy        = (state_q != IDLE) || (outstanding_q != '0);
  end

endmodule
